// File: rtl/cordic_iter_core_if.sv
// rtl/cordic_iter_core_if.sv - operand/result handshake bundle for cordic_iter_core
interface cordic_iter_core_if #(
    parameter int WIDTH = 15
);
    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              m;
    logic                    vec;
    logic signed [WIDTH:0]   Xo;
    logic signed [WIDTH:0]   Yo;
    logic signed [WIDTH:0]   Zo;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH:0]   Xout;
    logic signed [WIDTH:0]   Yout;
    logic signed [WIDTH:0]   Zout;
    logic                    ovf;

    modport master (
        output in_valid, m, vec, Xo, Yo, Zo, out_ready,
        input  in_ready, out_valid, Xout, Yout, Zout, ovf
    );

    modport slave (
        input  in_valid, m, vec, Xo, Yo, Zo, out_ready,
        output in_ready, out_valid, Xout, Yout, Zout, ovf
    );
endinterface

// File: rtl/cordic_iter_core.sv
// rtl/cordic_iter_core.sv - iterative CORDIC, one micro-rotation per clock; CORDIC_LINEAR_EN adds linear mode
module cordic_iter_core #(
    parameter int WIDTH = 15,
    parameter int FRAC  = 10,
    parameter int ITER  = 14
) (
    input  logic              clk,
    input  logic              reset,
    cordic_iter_core_if.slave bus
);
    // Two integer guard bits above the I/O word keep intermediate growth from wrapping.
    localparam int W     = WIDTH + 3;
    localparam int CW    = $clog2(ITER + 1);
    localparam int ROM_N = 1 << CW;
    localparam int SW    = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Hyperbolic shift sequence: 1,2,3,4,4,5,..,13,13,14,.. (repeat at 4, 13, 40, ...).
    function automatic int hyp_shift(input int idx);
        int s;
        int rep;
        int n;
        int res;
        s   = 1;
        rep = 4;
        n   = 0;
        res = 1;
        for (int k = 0; k < 64; k++) begin
            if (n == idx) res = s;
            n++;
            if (s == rep) begin
                if (n == idx) res = s;
                n++;
                rep = 3 * rep + 1;
            end
            s++;
        end
        return res;
    endfunction

    // Clamp to the output word; top bit of the result flags that a clamp happened.
    function automatic logic [WIDTH+1:0] sat(input logic signed [W-1:0] v);
        if (v[W-1:WIDTH] == {(W - WIDTH){v[W-1]}})
            return {1'b0, v[WIDTH:0]};
        else if (v[W-1])
            return {1'b1, 1'b1, {WIDTH{1'b0}}};
        else
            return {1'b1, 1'b0, {WIDTH{1'b1}}};
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [W-1:0]   x_q, y_q, z_q;
    logic                  vec_q;
    logic                  hyp_q;
    logic signed [WIDTH:0] xout_q, yout_q, zout_q;
    logic                  ovf_q;
    logic                  load, step, capture;

    logic [SW-1:0]         hyp_sh   [ROM_N];
    logic signed [W-1:0]   circ_ang [ROM_N];
    logic signed [W-1:0]   hyp_ang  [ROM_N];

    logic [SW-1:0]         sh;
    logic signed [W-1:0]   ang, xs, ys, x_rot, y_rot, z_rot;
    logic                  d_neg;
    logic [WIDTH+1:0]      sx, sy, sz;

`ifdef CORDIC_LINEAR_EN
    localparam logic signed [W-1:0] LIN_ONE = W'(1 << FRAC);
    logic lin_q;
`else
    logic unused_m1;
    assign unused_m1 = bus.m[1];
`endif

    // Angle and shift tables, computed at elaboration and rounded to nearest.
    for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
        if (gi < ITER) begin : g_used
            localparam int SH = hyp_shift(gi);
            localparam int CA = $rtoi($atan(1.0 / (2.0 ** gi)) * (2.0 ** FRAC) + 0.5);
            localparam int HA = $rtoi($atanh(1.0 / (2.0 ** SH)) * (2.0 ** FRAC) + 0.5);
            assign hyp_sh[gi]   = SW'(SH);
            assign circ_ang[gi] = W'(CA);
            assign hyp_ang[gi]  = W'(HA);
        end else begin : g_pad
            assign hyp_sh[gi]   = '0;
            assign circ_ang[gi] = '0;
            assign hyp_ang[gi]  = '0;
        end
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencing: accept in IDLE, ITER rotations plus one saturate cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(ITER)) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One micro-rotation on the working registers for the current step.
    always_comb begin
        sh    = hyp_q ? hyp_sh[cnt_q] : SW'(cnt_q);
        ang   = hyp_q ? hyp_ang[cnt_q] : circ_ang[cnt_q];
`ifdef CORDIC_LINEAR_EN
        if (lin_q) begin
            sh  = SW'(cnt_q);
            ang = LIN_ONE >>> sh;
        end
`endif
        xs    = x_q >>> sh;
        ys    = y_q >>> sh;
        // d_neg means d = -1: rotation follows sign(Z), vectoring opposes sign(Y).
        d_neg = vec_q ? ~y_q[W-1] : z_q[W-1];
        if (hyp_q)
            x_rot = d_neg ? x_q - ys : x_q + ys;
        else
            x_rot = d_neg ? x_q + ys : x_q - ys;
`ifdef CORDIC_LINEAR_EN
        if (lin_q) x_rot = x_q;
`endif
        y_rot = d_neg ? y_q - xs : y_q + xs;
        z_rot = d_neg ? z_q + ang : z_q - ang;
        sx    = sat(x_q);
        sy    = sat(y_q);
        sz    = sat(z_q);
    end

    // Working registers: latch operands on accept, update once per RUN step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            vec_q <= 1'b0;
            hyp_q <= 1'b0;
`ifdef CORDIC_LINEAR_EN
            lin_q <= 1'b0;
`endif
        end else if (load) begin
            x_q   <= {{(W - WIDTH - 1){bus.Xo[WIDTH]}}, bus.Xo};
            y_q   <= {{(W - WIDTH - 1){bus.Yo[WIDTH]}}, bus.Yo};
            z_q   <= {{(W - WIDTH - 1){bus.Zo[WIDTH]}}, bus.Zo};
            vec_q <= bus.vec;
            hyp_q <= bus.m[0];
`ifdef CORDIC_LINEAR_EN
            lin_q <= (bus.m == 2'b10);
`endif
        end else if (step) begin
            x_q <= x_rot;
            y_q <= y_rot;
            z_q <= z_rot;
        end
    end

    // Result registers: saturated words captured once, held through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xout_q <= '0;
            yout_q <= '0;
            zout_q <= '0;
            ovf_q  <= 1'b0;
        end else if (capture) begin
            xout_q <= sx[WIDTH:0];
            yout_q <= sy[WIDTH:0];
            zout_q <= sz[WIDTH:0];
            ovf_q  <= sx[WIDTH+1] | sy[WIDTH+1] | sz[WIDTH+1];
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.Xout      = xout_q;
    assign bus.Yout      = yout_q;
    assign bus.Zout      = zout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cordic_iter_core.sv
// tb/tb_cordic_iter_core.sv - randomized and directed bench for cordic_iter_core
module tb_cordic_iter_core;
    localparam int  WIDTH = 15;
    localparam int  FRAC  = 10;
    localparam int  ITER  = 14;
    localparam real SCALE = 1024.0;
    localparam int  TOL   = 4;
    localparam int  TOL_R = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cordic_iter_core_if #(.WIDTH(WIDTH)) bus ();

    cordic_iter_core #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    real kc;
    real kh;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int to_fix(input real r);
        int v;
        if (r >= 0.0) v = $rtoi(r * SCALE + 0.5);
        else          v = -$rtoi(-r * SCALE + 0.5);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    // Gains of the whole rotation sequence, from the shift schedule.
    task automatic compute_gains();
        int seq[$];
        int s;
        kc = 1.0;
        for (int i = 0; i < ITER; i++) kc = kc * $sqrt(1.0 + 2.0 ** (-2 * i));
        s = 1;
        while (seq.size() < ITER) begin
            seq.push_back(s);
            if ((s == 4 || s == 13 || s == 40) && seq.size() < ITER) seq.push_back(s);
            s++;
        end
        kh = 1.0;
        foreach (seq[i]) kh = kh * $sqrt(1.0 - 2.0 ** (-2 * seq[i]));
    endtask

    // Ideal result from closed-form trig/hyperbolic functions, scaled by the gain.
    task automatic ref_op(input int x, input int y, input int z, input bit hyp, input bit vv,
                          output int ex, output int ey, output int ez);
        real xr, yr, zr;
        xr = x / SCALE;
        yr = y / SCALE;
        zr = z / SCALE;
        if (!hyp && !vv) begin
            ex = to_fix(kc * (xr * $cos(zr) - yr * $sin(zr)));
            ey = to_fix(kc * (yr * $cos(zr) + xr * $sin(zr)));
            ez = 0;
        end else if (!hyp && vv) begin
            ex = to_fix(kc * $sqrt(xr * xr + yr * yr));
            ey = 0;
            ez = to_fix(zr + $atan2(yr, xr));
        end else if (hyp && !vv) begin
            ex = to_fix(kh * (xr * $cosh(zr) + yr * $sinh(zr)));
            ey = to_fix(kh * (yr * $cosh(zr) + xr * $sinh(zr)));
            ez = 0;
        end else begin
            ex = to_fix(kh * $sqrt(xr * xr - yr * yr));
            ey = 0;
            ez = to_fix(zr + $atanh(yr / xr));
        end
    endtask

    task automatic run_op(input logic signed [15:0] x, input logic signed [15:0] y,
                          input logic signed [15:0] z, input logic [1:0] mm, input logic vv,
                          output logic signed [15:0] xo, output logic signed [15:0] yo,
                          output logic signed [15:0] zo, output logic ov, output int lat);
        @(negedge clk);
        bus.Xo = x;
        bus.Yo = y;
        bus.Zo = z;
        bus.m = mm;
        bus.vec = vv;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        xo = bus.Xout;
        yo = bus.Yout;
        zo = bus.Zout;
        ov = bus.ovf;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.ovf, bus.Xout, bus.Yout, bus.Zout} !== '0) begin
            failures++;
            $display("FAIL reset_initial: in_ready=%b out_valid=%b X=%h Y=%h Z=%h ovf=%b, all required 0",
                     bus.in_ready, bus.out_valid, bus.Xout, bus.Yout, bus.Zout, bus.ovf);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_in_ready: got %b required 1", bus.in_ready);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.ovf, bus.Xout, bus.Yout, bus.Zout} !== '0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: in_ready=%b out_valid=%b X=%h, all required 0",
                         i, bus.in_ready, bus.out_valid, bus.Xout);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_hyperbolic_rotation();
        logic signed [15:0] xo, yo, zo;
        logic ov;
        int lat;
        for (int k = 0; k < 2; k++) begin
            run_op(16'sh04D4, 16'sh0000, 16'sh0320, (k == 0) ? 2'b01 : 2'b11, 1'b0, xo, yo, zo, ov, lat);
            checks++;
            if (lat !== ITER + 1) begin
                failures++;
                $display("FAIL hyp_rot_latency m%0d: got %0d required %0d", k, lat, ITER + 1);
            end
            checks++;
            if (iabs(int'(xo) - 'h548) > TOL || iabs(int'(yo) - 'h374) > TOL || iabs(int'(zo)) > TOL) begin
                failures++;
                $display("FAIL hyp_rot_value m%0d: got X=%h Y=%h Z=%h required X=0548 Y=0374 Z=0000 +/-%0d",
                         k, xo, yo, zo, TOL);
            end
        end
    endtask

    task automatic test_circular_rotation();
        logic signed [15:0] xo, yo, zo;
        logic ov;
        int lat;
        run_op(16'sh026E, 16'sh0000, 16'sh0324, 2'b00, 1'b0, xo, yo, zo, ov, lat);
        checks++;
        if (lat !== ITER + 1) begin
            failures++;
            $display("FAIL circ_rot_latency: got %0d required %0d", lat, ITER + 1);
        end
        checks++;
        if (iabs(int'(xo) - 'h2D4) > TOL || iabs(int'(yo) - 'h2D4) > TOL || iabs(int'(zo)) > TOL || ov !== 1'b0) begin
            failures++;
            $display("FAIL circ_rot_value: got X=%h Y=%h Z=%h ovf=%b required X=02D4 Y=02D4 Z=0000 ovf=0",
                     xo, yo, zo, ov);
        end
    endtask

    task automatic test_circular_vectoring();
        logic signed [15:0] xo, yo, zo;
        logic ov;
        int lat;
        run_op(16'sh0400, 16'sh0400, 16'sh0000, 2'b00, 1'b1, xo, yo, zo, ov, lat);
        checks++;
        if (iabs(int'(xo) - 'h951) > TOL || iabs(int'(yo)) > TOL || iabs(int'(zo) - 'h324) > TOL) begin
            failures++;
            $display("FAIL circ_vec_value: got X=%h Y=%h Z=%h required X=0951 Y=0000 Z=0324",
                     xo, yo, zo);
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] xo, yo, zo;
        logic ov;
        int lat, ex, ey, ez;
        for (int k = 0; k < 2; k++) begin
            logic signed [15:0] xin;
            xin = (k == 0) ? 16'sh7000 : -16'sh7000;
            ref_op(int'(xin), 0, 0, 1'b0, 1'b0, ex, ey, ez);
            run_op(xin, 16'sh0000, 16'sh0000, 2'b00, 1'b0, xo, yo, zo, ov, lat);
            checks++;
            if (int'(xo) !== ex || ov !== 1'b1) begin
                failures++;
                $display("FAIL saturation %0d: got X=%h ovf=%b required X=%h ovf=1", k, xo, ov, 16'(ex));
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] xs, ys, zs;
        logic os;
        int n;
        @(negedge clk);
        bus.Xo = 16'sh026E;
        bus.Yo = 16'sh0000;
        bus.Zo = 16'sh0324;
        bus.m = 2'b00;
        bus.vec = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_timeout: out_valid=%b required 1", bus.out_valid);
        end
        xs = bus.Xout;
        ys = bus.Yout;
        zs = bus.Zout;
        os = bus.ovf;
        checks++;
        if (iabs(int'(xs) - 'h2D4) > TOL || iabs(int'(ys) - 'h2D4) > TOL) begin
            failures++;
            $display("FAIL backpressure_value: got X=%h Y=%h required 02D4 02D4", xs, ys);
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.Xo = 16'($urandom);
            bus.m = 2'($urandom);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.Xout !== xs ||
                bus.Yout !== ys || bus.Zout !== zs || bus.ovf !== os) begin
                failures++;
                $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b X=%h Y=%h Z=%h required 1 0 %h %h %h",
                         i, bus.out_valid, bus.in_ready, bus.Xout, bus.Yout, bus.Zout, xs, ys, zs);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_during_run();
        logic signed [15:0] xo, yo, zo;
        logic ov;
        int lat;
        bit seen;
        @(negedge clk);
        bus.Xo = 16'sh04D4;
        bus.Yo = 16'sh0000;
        bus.Zo = 16'sh0320;
        bus.m = 2'b01;
        bus.vec = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.ovf, bus.Xout, bus.Yout, bus.Zout} !== '0) begin
            failures++;
            $display("FAIL reset_in_run: in_ready=%b out_valid=%b X=%h Y=%h Z=%h, all required 0",
                     bus.in_ready, bus.out_valid, bus.Xout, bus.Yout, bus.Zout);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (ITER + 4) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_run_discard: out_valid seen=%b required 0", seen);
        end
        run_op(16'sh026E, 16'sh0000, 16'sh0324, 2'b00, 1'b0, xo, yo, zo, ov, lat);
        checks++;
        if (lat !== ITER + 1 || iabs(int'(xo) - 'h2D4) > TOL || iabs(int'(yo) - 'h2D4) > TOL) begin
            failures++;
            $display("FAIL after_reset_op: lat=%0d X=%h Y=%h required lat=%0d X=02D4 Y=02D4",
                     lat, xo, yo, ITER + 1);
        end
    endtask

    task automatic test_linear_mode();
        logic signed [15:0] xo, yo, zo;
        logic ov;
        int lat, ex, ey, ez;
`ifdef CORDIC_LINEAR_EN
        ex = 'h200;
        ey = 'h180;
        ez = 0;
`else
        ref_op('h200, 0, 'h300, 1'b0, 1'b0, ex, ey, ez);
`endif
        run_op(16'sh0200, 16'sh0000, 16'sh0300, 2'b10, 1'b0, xo, yo, zo, ov, lat);
        checks++;
        if (iabs(int'(xo) - ex) > TOL || iabs(int'(yo) - ey) > TOL || iabs(int'(zo) - ez) > TOL) begin
            failures++;
            $display("FAIL mode_10: got X=%h Y=%h Z=%h required X=%h Y=%h Z=%h",
                     xo, yo, zo, 16'(ex), 16'(ey), 16'(ez));
        end
    endtask

    task automatic test_random();
        logic signed [15:0] xo, yo, zo;
        logic ov;
        int lat, x, y, z, lim, ex, ey, ez, kind;
        for (int i = 0; i < 24; i++) begin
            kind = i % 4;
            case (kind)
                0: begin
                    x = int'($urandom_range(0, 6144)) - 3072;
                    y = int'($urandom_range(0, 6144)) - 3072;
                    z = int'($urandom_range(0, 3072)) - 1536;
                end
                1: begin
                    x = int'($urandom_range(512, 3072));
                    y = int'($urandom_range(0, 6144)) - 3072;
                    z = int'($urandom_range(0, 1024)) - 512;
                end
                2: begin
                    x = int'($urandom_range(1024, 3072));
                    y = int'($urandom_range(0, 1024)) - 512;
                    z = int'($urandom_range(0, 2048)) - 1024;
                end
                default: begin
                    x = int'($urandom_range(1024, 3072));
                    lim = x * 7 / 10;
                    y = int'($urandom_range(0, 2 * lim)) - lim;
                    z = int'($urandom_range(0, 512)) - 256;
                end
            endcase
            ref_op(x, y, z, kind[1], kind[0], ex, ey, ez);
            run_op(16'(x), 16'(y), 16'(z), {1'b0, kind[1]}, kind[0], xo, yo, zo, ov, lat);
            checks++;
            if (lat !== ITER + 1 || ov !== 1'b0 || iabs(int'(xo) - ex) > TOL_R ||
                iabs(int'(yo) - ey) > TOL_R || iabs(int'(zo) - ez) > TOL_R) begin
                failures++;
                $display("FAIL random %0d kind %0d in X=%0d Y=%0d Z=%0d: got lat=%0d ovf=%b X=%0d Y=%0d Z=%0d required lat=%0d ovf=0 X=%0d Y=%0d Z=%0d",
                         i, kind, x, y, z, lat, ov, xo, yo, zo, ITER + 1, ex, ey, ez);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.m = 2'b00;
        bus.vec = 1'b0;
        bus.Xo = '0;
        bus.Yo = '0;
        bus.Zo = '0;
        compute_gains();
        test_reset();
        test_hyperbolic_rotation();
        test_circular_rotation();
        test_circular_vectoring();
        test_saturation();
        test_backpressure();
        test_reset_during_run();
        test_linear_mode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
